// File: rtl/fib_controller.sv
// Sequencing FSM for the stack-based customized-Fibonacci datapath.
// Evaluates F(N) by iterative post-order reduction on the datapath stack.
//
// state | meaning
// IDLE  | waiting for start, no result yet
// DONE  | result valid in res, waiting for start
// PUSHN | push N as the root argument
// FETCH | load reg1/reg2 from the stack top
// DEC1  | classify top entry: value, expandable argument, or base case
// EXP1  | push a-2
// EXP2  | push a-1 (evaluated first)
// BPOP  | drop base-case argument
// BPUSH | push flagged constant 1
// POPV  | pop a computed value (already in reg1)
// CHK   | stack empty -> finished, else peek entry below into reg2
// DEC2  | sibling unresolved -> swap, else combine
// SWP0-2| swap value below its unresolved sibling
// CPOP  | drop F(n-1)
// CLD3  | load parent argument n into reg3
// CPOP3 | drop parent argument
// CALC  | res = (n-1)*F(n-1) + (n-2)*F(n-2)
// CPUSH | push flagged res
module fib_controller (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       is_empty,
   input  logic       gt1,
   input  logic       gt2,
   input  logic       gt3,
   input  logic       reg1_sign,
   input  logic       reg2_sign,
   output logic       push,
   output logic       pop,
   output logic       top,
   output logic       ld1,
   output logic       ld2,
   output logic       ld3,
   output logic       ld_res,
   output logic       sel_reg1,
   output logic       sel_reg2,
   output logic       sel,
   output logic       sel_res,
   output logic [2:0] sel_stack,
   output logic       done,
   output logic       busy
);

   typedef enum logic [4:0] {
      S_IDLE, S_DONE, S_PUSHN, S_FETCH, S_DEC1, S_EXP1, S_EXP2,
      S_BPOP, S_BPUSH, S_POPV, S_CHK, S_DEC2, S_SWP0, S_SWP1, S_SWP2,
      S_CPOP, S_CLD3, S_CPOP3, S_CALC, S_CPUSH
   } state_t;

   state_t state, state_next;

   // gt2 describes reg2 magnitude, which the sequencing never needs
   logic unused_gt2;
   assign unused_gt2 = gt2;

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      push       = 1'b0;
      pop        = 1'b0;
      top        = 1'b0;
      ld1        = 1'b0;
      ld2        = 1'b0;
      ld3        = 1'b0;
      ld_res     = 1'b0;
      sel_reg1   = 1'b0;
      sel_reg2   = 1'b0;
      sel        = 1'b0;
      sel_res    = 1'b0;
      sel_stack  = 3'd0;
      done       = 1'b0;
      busy       = 1'b1;
      case (state)
         S_IDLE, S_DONE: begin
            busy = 1'b0;
            done = (state == S_DONE);
            if (start && !rst) begin
               if (gt3) begin
                  state_next = S_PUSHN;
               end else begin
                  ld_res     = 1'b1;
                  sel_res    = 1'b1;
                  state_next = S_DONE;
               end
            end
         end
         S_PUSHN: begin
            push       = 1'b1;
            state_next = S_FETCH;
         end
         S_FETCH: begin
            top        = 1'b1;
            ld1        = 1'b1;
            ld2        = 1'b1;
            state_next = S_DEC1;
         end
         S_DEC1: begin
            if (reg1_sign) state_next = S_POPV;
            else if (gt1)  state_next = S_EXP1;
            else           state_next = S_BPOP;
         end
         S_EXP1: begin
            push       = 1'b1;
            sel_stack  = 3'd2;
            sel_reg2   = 1'b1;
            state_next = S_EXP2;
         end
         S_EXP2: begin
            push       = 1'b1;
            sel_stack  = 3'd1;
            sel_reg1   = 1'b1;
            state_next = S_FETCH;
         end
         S_BPOP: begin
            pop        = 1'b1;
            state_next = S_BPUSH;
         end
         S_BPUSH: begin
            push       = 1'b1;
            sel_stack  = 3'd5;
            state_next = S_FETCH;
         end
         S_POPV: begin
            pop        = 1'b1;
            state_next = S_CHK;
         end
         S_CHK: begin
            if (is_empty) begin
               state_next = S_DONE;
            end else begin
               top        = 1'b1;
               ld2        = 1'b1;
               state_next = S_DEC2;
            end
         end
         S_DEC2: begin
            if (reg2_sign) state_next = S_CPOP;
            else           state_next = S_SWP0;
         end
         S_SWP0: begin
            pop        = 1'b1;
            state_next = S_SWP1;
         end
         S_SWP1: begin
            push       = 1'b1;
            sel_stack  = 3'd1;
            state_next = S_SWP2;
         end
         S_SWP2: begin
            push       = 1'b1;
            sel_stack  = 3'd2;
            state_next = S_FETCH;
         end
         S_CPOP: begin
            pop        = 1'b1;
            state_next = S_CLD3;
         end
         S_CLD3: begin
            top        = 1'b1;
            ld3        = 1'b1;
            state_next = S_CPOP3;
         end
         S_CPOP3: begin
            pop        = 1'b1;
            state_next = S_CALC;
         end
         S_CALC: begin
            ld_res     = 1'b1;
            sel        = 1'b1;
            state_next = S_CPUSH;
         end
         S_CPUSH: begin
            push       = 1'b1;
            sel_stack  = 3'd3;
            state_next = S_FETCH;
         end
         default: begin
            busy       = 1'b0;
            state_next = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_fib_controller.sv
// Bench for fib_controller: behavioural stack datapath around the FSM,
// results compared with F(N) computed directly from the recurrence.
module tb_fib_controller;
   logic        clk = 1'b0;
   logic        rst, start;
   logic        is_empty, gt1, gt2, gt3, reg1_sign, reg2_sign;
   logic        push, pop, top, ld1, ld2, ld3, ld_res;
   logic        sel_reg1, sel_reg2, sel, sel_res;
   logic [2:0]  sel_stack;
   logic        done, busy;
   int          vectors = 0;
   int          miscompares = 0;

   always #5 clk = ~clk;

   fib_controller dut (
      .clk(clk), .rst(rst), .start(start),
      .is_empty(is_empty), .gt1(gt1), .gt2(gt2), .gt3(gt3),
      .reg1_sign(reg1_sign), .reg2_sign(reg2_sign),
      .push(push), .pop(pop), .top(top), .ld1(ld1), .ld2(ld2), .ld3(ld3),
      .ld_res(ld_res), .sel_reg1(sel_reg1), .sel_reg2(sel_reg2), .sel(sel),
      .sel_res(sel_res), .sel_stack(sel_stack), .done(done), .busy(busy)
   );

   // datapath model: stack, reg1/2/3, res
   logic [62:0] n_val;
   logic [63:0] stk [0:127];
   logic [6:0]  sp;
   logic [63:0] reg1, reg2, reg3, res;
   logic [63:0] stack_out, stack_in, calc;
   int          push_count = 0;

   assign stack_out = (sp != 7'd0) ? stk[sp - 7'd1] : 64'd0;
   assign is_empty  = (sp == 7'd0);
   assign gt1       = reg1[62:0] > 63'd1;
   assign gt2       = reg2[62:0] > 63'd1;
   assign gt3       = n_val > 63'd1;
   assign reg1_sign = reg1[63];
   assign reg2_sign = reg2[63];

   always_comb begin
      stack_in = 64'd0;
      case (sel_stack)
         3'd0: stack_in = {1'b0, n_val};
         3'd1: stack_in = sel_reg1 ? reg1 - 64'd1 : reg1;
         3'd2: stack_in = sel_reg2 ? reg2 - 64'd2 : reg2;
         3'd3: stack_in = {1'b1, res[62:0]};
         3'd5: stack_in = {1'b1, 63'd1};
         default: stack_in = 64'd0;
      endcase
   end

   always_comb begin
      calc = 64'd0;
      if (sel)
         calc = ({1'b0, reg3[62:0]} - 64'd1) * {1'b0, reg2[62:0]}
              + ({1'b0, reg3[62:0]} - 64'd2) * {1'b0, reg1[62:0]};
   end

   always @(posedge clk) begin
      if (rst) begin
         sp   <= 7'd0;
         reg1 <= 64'd0;
         reg2 <= 64'd0;
         reg3 <= 64'd0;
         res  <= 64'd0;
      end else begin
         if (push) begin
            stk[sp]    <= stack_in;
            sp         <= sp + 7'd1;
            push_count <= push_count + 1;
         end else if (pop && sp != 7'd0) begin
            sp <= sp - 7'd1;
         end
         if (ld1)    reg1 <= stack_out;
         if (ld2)    reg2 <= stack_out;
         if (ld3)    reg3 <= stack_out;
         if (ld_res) res  <= sel_res ? 64'd1 : calc;
      end
   end

   // protocol monitor
   always @(negedge clk) begin
      if (rst === 1'b0) begin
         vectors++;
         if (push && pop) begin
            miscompares++;
            $display("FAIL proto_push_pop: push=%b pop=%b, required not both", push, pop);
         end
         if ((ld1 || ld2 || ld3) && !top) begin
            miscompares++;
            $display("FAIL proto_ld_top: ld=%b%b%b top=%b, required top=1", ld1, ld2, ld3, top);
         end
         if (sel_stack == 3'd4 || sel_stack >= 3'd6) begin
            miscompares++;
            $display("FAIL proto_sel_stack: got %0d, required not 4/6/7", sel_stack);
         end
         if (pop && is_empty) begin
            miscompares++;
            $display("FAIL proto_pop_empty: pop with empty stack");
         end
      end
   end

   function automatic logic [63:0] fib_ref(input int n);
      logic [63:0] f0, f1, f;
      f0 = 64'd1;
      f1 = 64'd1;
      for (int k = 2; k <= n; k++) begin
         f  = 64'(k - 1) * f1 + 64'(k - 2) * f0;
         f0 = f1;
         f1 = f;
      end
      return f1;
   endfunction

   // starts a run and returns edges from the start-sampling edge until done
   task automatic run_n(input int n, input int pulse_at, output int lat, output bit timed_out);
      @(negedge clk);
      n_val = 63'(n);
      start = 1'b1;
      @(posedge clk);
      lat = 1;
      @(negedge clk);
      start = 1'b0;
      while (!done && lat < 5000) begin
         start = (lat == pulse_at);
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      start = 1'b0;
      timed_out = !done;
   endtask

   task automatic test_reset();
      logic [15:0] outs;
      rst   = 1'b1;
      start = 1'b0;
      n_val = 63'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      outs = {push, pop, top, ld1, ld2, ld3, ld_res, sel_reg1, sel_reg2,
              sel, sel_res, sel_stack, done, busy};
      vectors++;
      if (outs !== 16'd0) begin
         miscompares++;
         $display("FAIL reset_outputs: got %h required 0000", outs);
      end
      rst = 1'b0;
   endtask

   task automatic test_small_n();
      int lat;
      bit to;
      int pc;
      for (int n = 0; n <= 1; n++) begin
         pc = push_count;
         run_n(n, 0, lat, to);
         vectors++;
         if (lat !== 1 || to) begin
            miscompares++;
            $display("FAIL small_latency N=%0d: got %0d required 1", n, lat);
         end
         vectors++;
         if (res !== 64'd1) begin
            miscompares++;
            $display("FAIL small_res N=%0d: got %0d required 1", n, res);
         end
         vectors++;
         if (push_count != pc) begin
            miscompares++;
            $display("FAIL small_no_push N=%0d: got %0d pushes required 0", n, push_count - pc);
         end
      end
   endtask

   task automatic test_n2();
      int lat;
      bit to;
      run_n(2, 0, lat, to);
      vectors++;
      if (lat !== 36 || to) begin
         miscompares++;
         $display("FAIL n2_latency: got %0d required 36", lat);
      end
      vectors++;
      if (res !== 64'd1 || is_empty !== 1'b1) begin
         miscompares++;
         $display("FAIL n2_result: got res=%0d empty=%b required res=1 empty=1", res, is_empty);
      end
   endtask

   task automatic test_fixed();
      int lat;
      bit to;
      bit held;
      logic [63:0] r;
      for (int n = 3; n <= 6; n++) begin
         run_n(n, 0, lat, to);
         vectors++;
         if (to || res !== fib_ref(n) || is_empty !== 1'b1) begin
            miscompares++;
            $display("FAIL fixed N=%0d: got res=%0d empty=%b timeout=%b required %0d", n, res, is_empty, to, fib_ref(n));
         end
         r    = res;
         held = 1'b1;
         repeat (5) begin
            @(negedge clk);
            if (!done || busy || res !== r) held = 1'b0;
         end
         vectors++;
         if (!held) begin
            miscompares++;
            $display("FAIL done_hold N=%0d: got done=%b res=%0d required done=1 res=%0d", n, done, res, r);
         end
      end
   endtask

   task automatic test_random();
      int lat;
      bit to;
      int n;
      for (int i = 0; i < 6; i++) begin
         n = int'($urandom_range(8, 0));
         run_n(n, 0, lat, to);
         vectors++;
         if (to || res !== fib_ref(n)) begin
            miscompares++;
            $display("FAIL random N=%0d: got res=%0d timeout=%b required %0d", n, res, to, fib_ref(n));
         end
      end
   endtask

   task automatic test_reset_mid();
      int lat;
      bit to;
      logic [15:0] outs;
      @(negedge clk);
      n_val = 63'd6;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (19) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      outs = {push, pop, top, ld1, ld2, ld3, ld_res, sel_reg1, sel_reg2,
              sel, sel_res, sel_stack, done, busy};
      vectors++;
      if (outs !== 16'd0 || is_empty !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_mid: got outs=%h empty=%b required 0000 empty=1", outs, is_empty);
      end
      rst = 1'b0;
      run_n(4, 0, lat, to);
      vectors++;
      if (to || res !== 64'd11) begin
         miscompares++;
         $display("FAIL after_reset N=4: got %0d required 11", res);
      end
   endtask

   task automatic test_back_to_back();
      int lat;
      bit to;
      run_n(4, 0, lat, to);
      vectors++;
      if (to || res !== 64'd11) begin
         miscompares++;
         $display("FAIL b2b_first N=4: got %0d required 11", res);
      end
      n_val = 63'd3;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      vectors++;
      if (done !== 1'b0 || busy !== 1'b1) begin
         miscompares++;
         $display("FAIL b2b_restart: got done=%b busy=%b required done=0 busy=1", done, busy);
      end
      repeat (2) @(negedge clk);
      start = 1'b0;
      lat = 0;
      while (!done && lat < 5000) begin
         @(negedge clk);
         lat++;
      end
      vectors++;
      if (!done || res !== 64'd3) begin
         miscompares++;
         $display("FAIL b2b_second N=3: got %0d done=%b required 3", res, done);
      end
      run_n(5, 30, lat, to);
      vectors++;
      if (to || res !== 64'd53) begin
         miscompares++;
         $display("FAIL midrun_start N=5: got %0d required 53", res);
      end
   endtask

   initial begin
      test_reset();
      test_small_n();
      test_n2();
      test_fixed();
      test_random();
      test_reset_mid();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
